// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the pipeline write-back
//   stage (WB) and the DMA engine. WB has priority. A DMA request blocked for
//   MAX_WAIT consecutive cycles forces a one-cycle pipeline stall so the DMA
//   can take the port.
//
// Handshake: dma_req is held with dma_wrA/dma_wrD until dma_gnt is seen high
//   in the same cycle; that cycle is the transfer. WB has no acknowledge: a WB
//   request not taken while stall_out=1 is re-presented by the frozen pipeline.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   wb_regW/wb_wrA/wb_wrD  WB write request, address, data
//   dma_req/dma_wrA/dma_wrD DMA write request, address, data
//   dma_gnt                combinational, DMA write accepted this cycle
//   stall_out              decoded from state register, high only in FORCE
//   rf_regW/rf_wrA/rf_wrD  registered register-file write port (1-cycle latency)
//   dma_wr_cnt, force_cnt  saturating statistics counters
//   state_dbg              current FSM state (0=IDLE, 1=WAIT, 2=FORCE)
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_regW,
  input  logic [4:0]       wb_wrA,
  input  logic [31:0]      wb_wrD,
  input  logic             dma_req,
  input  logic [4:0]       dma_wrA,
  input  logic [31:0]      dma_wrD,
  output logic             dma_gnt,
  output logic             stall_out,
  output logic             rf_regW,
  output logic [4:0]       rf_wrA,
  output logic [31:0]      rf_wrD,
  output logic [CNT_W-1:0] dma_wr_cnt,
  output logic [CNT_W-1:0] force_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] wait_inc;
  logic       win_wb;
  logic       win_dma;

  assign wait_inc = wait_q + 4'd1;

  // Winner selection. In FORCE only the DMA may write; if it has dropped its
  // request the port stays idle for that cycle. A reset cycle never grants,
  // so a pending DMA request is dropped without acknowledgement.
  always_comb begin
    win_wb  = 1'b0;
    win_dma = 1'b0;
    if (!rst) begin
      if (state_q == FORCE) begin
        win_dma = dma_req;
      end else if (wb_regW) begin
        win_wb = 1'b1;
      end else begin
        win_dma = dma_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (dma_req && wb_regW) begin
          if (MAX_WAIT_C == 4'd1) begin
            state_d = FORCE;
            wait_d  = 4'd0;
          end else begin
            state_d = WAIT;
            wait_d  = 4'd1;
          end
        end
      end
      WAIT: begin
        if (!dma_req || !wb_regW) begin
          // Either the DMA was granted or it withdrew its request.
          state_d = IDLE;
          wait_d  = 4'd0;
        end else if (wait_inc == MAX_WAIT_C) begin
          state_d = FORCE;
          wait_d  = 4'd0;
        end else begin
          wait_d = wait_inc;
        end
      end
      FORCE: begin
        state_d = IDLE;
        wait_d  = 4'd0;
      end
      default: begin
        state_d = IDLE;
        wait_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= 4'd0;
      rf_regW    <= 1'b0;
      rf_wrA     <= 5'd0;
      rf_wrD     <= 32'd0;
      dma_wr_cnt <= '0;
      force_cnt  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rf_regW <= win_wb | win_dma;
      // Address 0 is forwarded unchanged; the register file discards it.
      if (win_wb) begin
        rf_wrA <= wb_wrA;
        rf_wrD <= wb_wrD;
      end else if (win_dma) begin
        rf_wrA <= dma_wrA;
        rf_wrD <= dma_wrD;
      end else begin
        rf_wrA <= 5'd0;
        rf_wrD <= 32'd0;
      end
      if (win_dma && (dma_wr_cnt != {CNT_W{1'b1}})) begin
        dma_wr_cnt <= dma_wr_cnt + 1'b1;
      end
      if ((state_q == FORCE) && (force_cnt != {CNT_W{1'b1}})) begin
        force_cnt <= force_cnt + 1'b1;
      end
    end
  end

  assign dma_gnt   = win_dma;
  assign stall_out = (state_q == FORCE);
  assign state_dbg = state_q;

endmodule
